count_seq_monitor: RTL
======================

COUNT_SEQ_MONITOR -- requirements
Module: count_seq_monitor

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  WRAP_W, 8, width of the wrap counter.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  input  1  single clock; all state changes on the rising edge.
  rst  input  1  reset, asynchronous, active-high.
  count4  input  [1:0]  mod-4 count under observation, synchronous to clk, no synchronizer.
  clr  input  1  synchronous clear of monitor state.
  locked  output  1  high while the FSM is in TRACK.
  wrap_pulse  output  1  one-cycle pulse per legal 3->0 wrap.
  wrap_count  output  [WRAP_W-1:0]  number of legal wraps since reset or clr, saturating.
  seq_err  output  1  sticky flag for an illegal transition.
  err_val  output  [1:0]  count4 value that caused the error.
  exp_val  output  [1:0]  last accepted count value (prev).
REQ-003 There SHALL be exactly one clock domain; rst SHALL be asynchronous and active-high.

Function
REQ-004 The FSM SHALL have three states: IDLE, TRACK and ERROR. All outputs SHALL be registered.
REQ-005 IDLE: if count4==0 is sampled, the FSM SHALL go to TRACK with prev<=0. Otherwise it SHALL stay in IDLE, with no counting and no error checking.
REQ-006 TRACK, for sampled count4 == prev: the FSM SHALL hold, with no change and no error.
REQ-007 TRACK, for count4 == prev+1 mod 4, with prev != 3: prev SHALL become count4, with no pulse.
REQ-008 TRACK, for prev==3 and count4==0: prev SHALL become 0 and wrap_count SHALL increment. wrap_pulse SHALL be 1 for exactly the one cycle after that edge.
REQ-009 TRACK, any other value (a skip or a backward step): the FSM SHALL go to ERROR, with seq_err<=1 and err_val<=count4. prev SHALL be unchanged and wrap_count SHALL be unchanged.
REQ-010 ERROR: the FSM SHALL ignore count4 and hold all outputs (wrap_pulse=0) until clr is sampled high.
REQ-011 clr sampled high in any state SHALL take precedence over all other events on that edge. Its effects on that edge SHALL be:
  - state<=IDLE
  - wrap_count<=0, wrap_pulse<=0
  - seq_err<=0, err_val<=0
  - prev<=0
REQ-012 wrap_count SHALL saturate at 2^WRAP_W-1. A wrap at saturation SHALL still pulse wrap_pulse and SHALL leave the count unchanged.
REQ-013 locked SHALL equal (state==TRACK) and SHALL be registered. It SHALL be 0 in IDLE and in ERROR.
REQ-014 The latency from a sampled event to a visible output change SHALL be exactly one clock edge. There SHALL be no combinational path from any input to any output.
REQ-015 wrap_pulse SHALL never be high on two consecutive cycles, because at least four edges separate two legal wraps.

Reset
REQ-016 While rst=1, the following SHALL hold asynchronously:
  - state=IDLE, prev=0
  - locked=0, wrap_pulse=0, wrap_count=0
  - seq_err=0, err_val=0, exp_val=0
REQ-017 rst deasserted mid-sequence SHALL restart the FSM in IDLE. Monitoring SHALL resume only when count4==0 is next sampled.
REQ-018 rst asserted while in ERROR SHALL clear seq_err without needing clr.

Verification
REQ-019 Case: reset, then count4 = 0,1,2,3,0,1,2,3,0 on consecutive cycles. Required response:
  - locked=1 from the edge after the first 0
  - wrap_pulse high exactly twice, each for one cycle
  - wrap_count=2, seq_err=0
REQ-020 Case: TRACK with count4 = 0,1,3. Required response:
  - seq_err=1, err_val=3, exp_val=1, locked=0
  - wrap_count unchanged
  - further count4 activity has no effect until clr
REQ-021 Case: count4 held at 2 for 10 cycles in TRACK, then 3,0. Required response:
  - no error
  - one wrap_pulse
  - wrap_count incremented by 1
REQ-022 Case: clr asserted on the same edge that samples the 3->0 wrap. Required response:
  - wrap_pulse=0, wrap_count=0
  - state=IDLE, locked=0
REQ-023 Case: WRAP_W=2, drive 5 full cycles. Required response:
  - wrap_count saturates at 3
  - wrap_pulse high on all 5 wraps
REQ-024 Case: rst pulsed asynchronously between clock edges while in ERROR. Required response:
  - outputs cleared immediately
  - after release, count4 = 1,2 ignored (locked=0)
  - count4=0 enters TRACK

Source files
------------

// File: rtl/count_seq_monitor.sv
// rtl/count_seq_monitor.sv - checks that a mod-4 count steps 0,1,2,3,0 and counts legal wraps
module count_seq_monitor #(
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        count4,
    input  logic              clr,
    output logic              locked,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              seq_err,
    output logic [1:0]        err_val,
    output logic [1:0]        exp_val
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        prev_q, prev_d;
    logic              locked_q, locked_d;
    logic              wrap_pulse_q, wrap_pulse_d;
    logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;
    logic              seq_err_q, seq_err_d;
    logic [1:0]        err_val_q, err_val_d;
    logic [1:0]        prev_inc;

    // The 2-bit add wraps 3 to 0 on its own, so one compare covers both steps and wraps.
    assign prev_inc = prev_q + 2'd1;

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        wrap_pulse_d = 1'b0;
        wrap_count_d = wrap_count_q;
        seq_err_d    = seq_err_q;
        err_val_d    = err_val_q;

        if (clr) begin
            state_d      = IDLE;
            prev_d       = 2'd0;
            wrap_count_d = '0;
            seq_err_d    = 1'b0;
            err_val_d    = 2'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (count4 == 2'd0) begin
                        state_d = TRACK;
                        prev_d  = 2'd0;
                    end
                end
                TRACK: begin
                    if (count4 == prev_q) begin
                        state_d = TRACK;
                    end else if (count4 == prev_inc) begin
                        prev_d = count4;
                        if (prev_q == 2'd3) begin
                            wrap_pulse_d = 1'b1;
                            if (wrap_count_q != {WRAP_W{1'b1}})
                                wrap_count_d = wrap_count_q + WRAP_W'(1);
                        end
                    end else begin
                        state_d   = ERROR;
                        seq_err_d = 1'b1;
                        err_val_d = count4;
                    end
                end
                ERROR: begin
                    state_d = ERROR;
                end
                default: begin
                    state_d = IDLE;
                    prev_d  = 2'd0;
                end
            endcase
        end

        // locked is registered from the next state so it tracks state with no extra lag.
        locked_d = (state_d == TRACK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            prev_q       <= 2'd0;
            locked_q     <= 1'b0;
            wrap_pulse_q <= 1'b0;
            wrap_count_q <= '0;
            seq_err_q    <= 1'b0;
            err_val_q    <= 2'd0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            locked_q     <= locked_d;
            wrap_pulse_q <= wrap_pulse_d;
            wrap_count_q <= wrap_count_d;
            seq_err_q    <= seq_err_d;
            err_val_q    <= err_val_d;
        end
    end

    assign locked     = locked_q;
    assign wrap_pulse = wrap_pulse_q;
    assign wrap_count = wrap_count_q;
    assign seq_err    = seq_err_q;
    assign err_val    = err_val_q;
    assign exp_val    = prev_q;

endmodule
